// File: rtl/valve_pulse_sched.sv
// Round-robin scheduler sharing one timed valve-drive output among NCH
// channels; pulses are whole milliseconds aligned to an internal tick.
module valve_pulse_sched #(
  parameter int NCH     = 4,
  parameter int CLK_DIV = 100000,
  parameter int DUR_W   = 16,
  parameter int GAP_MS  = 2
) (
  input  logic                   clk_100m,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*DUR_W-1:0]   dur_ms,
  input  logic                   abort,
  output logic [NCH-1:0]         grant,
  output logic                   valve_on,
  output logic [NCH-1:0]         done,
  output logic                   aborted,
  output logic                   busy,
  output logic                   ms_tick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int LW = (NCH > 2) ? $clog2(NCH) : 1;
  localparam int GW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_ACTIVE,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    presc_q;
  logic [LW-1:0]    last_q;
  logic [DUR_W-1:0] rem_q;
  logic [GW-1:0]    gcnt_q;
  logic [NCH-1:0]   grant_q;
  logic             valve_q;
  logic [NCH-1:0]   done_q;
  logic             abrt_q;

  logic [LW-1:0]    pick;
  logic [NCH-1:0]   pick_oh;
  logic [DUR_W-1:0] pick_dur;
  logic             tick;

  // First requester at or after last_q+1, wrapping around.
  function automatic logic [LW-1:0] rr_pick(
    input logic [NCH-1:0] r,
    input logic [LW-1:0]  last
  );
    logic [LW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last) + k) % NCH;
      if (!found && r[idx]) begin
        sel   = LW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick     = rr_pick(req, last_q);
    pick_oh  = {{(NCH-1){1'b0}}, 1'b1} << pick;
    pick_dur = dur_ms[pick*DUR_W +: DUR_W];
  end

  assign tick    = (presc_q == PW'(CLK_DIV-1));
  assign ms_tick = tick;

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= LW'(NCH-1);
      rem_q   <= '0;
      gcnt_q  <= '0;
      grant_q <= '0;
      valve_q <= 1'b0;
      done_q  <= '0;
      abrt_q  <= 1'b0;
    end else begin
      done_q <= '0;
      abrt_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            grant_q <= pick_oh;
            last_q  <= pick;
            rem_q   <= pick_dur;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          // Zero-length request completes without driving the valve.
          if (rem_q == '0) begin
            grant_q <= '0;
            done_q  <= grant_q;
            state_q <= S_IDLE;
          end else if (abort) begin
            grant_q <= '0;
            done_q  <= grant_q;
            abrt_q  <= 1'b1;
            gcnt_q  <= '0;
            state_q <= S_GAP;
          end else if (tick) begin
            valve_q <= 1'b1;
            state_q <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (abort) begin
            valve_q <= 1'b0;
            grant_q <= '0;
            done_q  <= grant_q;
            abrt_q  <= 1'b1;
            gcnt_q  <= '0;
            state_q <= S_GAP;
          end else if (tick) begin
            if (rem_q == DUR_W'(1)) begin
              valve_q <= 1'b0;
              grant_q <= '0;
              done_q  <= grant_q;
              gcnt_q  <= '0;
              state_q <= S_GAP;
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end
        end
        S_GAP: begin
          if (GAP_MS == 0) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            if (gcnt_q == GW'(GAP_MS-1)) begin
              state_q <= S_IDLE;
            end else begin
              gcnt_q <= gcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign valve_on = valve_q;
  assign done     = done_q;
  assign aborted  = abrt_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_valve_pulse_sched.sv
// Directed bench for valve_pulse_sched with CLK_DIV=10, GAP_MS=2.
module tb_valve_pulse_sched;

  localparam int NCH     = 4;
  localparam int CLK_DIV = 10;
  localparam int DUR_W   = 16;
  localparam int GAP_MS  = 2;
  localparam int BOUND   = 300;

  logic                 clk_100m = 1'b0;
  logic                 rst      = 1'b0;
  logic [NCH-1:0]       req      = '0;
  logic [NCH*DUR_W-1:0] dur_ms   = '0;
  logic                 abort    = 1'b0;
  logic [NCH-1:0]       grant;
  logic                 valve_on;
  logic [NCH-1:0]       done;
  logic                 aborted;
  logic                 busy;
  logic                 ms_tick;

  int n      = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  valve_pulse_sched #(
    .NCH    (NCH),
    .CLK_DIV(CLK_DIV),
    .DUR_W  (DUR_W),
    .GAP_MS (GAP_MS)
  ) dut (
    .clk_100m(clk_100m),
    .rst     (rst),
    .req     (req),
    .dur_ms  (dur_ms),
    .abort   (abort),
    .grant   (grant),
    .valve_on(valve_on),
    .done    (done),
    .aborted (aborted),
    .busy    (busy),
    .ms_tick (ms_tick)
  );

  always #5 clk_100m = ~clk_100m;

  // Cycles since reset release; prescaler value is n % CLK_DIV.
  always @(posedge clk_100m or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic step();
    @(negedge clk_100m);
  endtask

  task automatic set_dur(input int ch, input int v);
    dur_ms[ch*DUR_W +: DUR_W] = DUR_W'(v);
  endtask

  task automatic do_reset();
    @(negedge clk_100m);
    rst = 1'b1;
    req = '0;
    abort = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_rise(output int c);
    c = 0;
    while (!valve_on && c < BOUND) begin
      step();
      c++;
    end
  endtask

  task automatic measure_high(output int c);
    c = 0;
    while (valve_on && c < BOUND) begin
      step();
      c++;
    end
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy && c < BOUND) begin
      step();
      c++;
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rst_grant: got %b want 0000", grant); end
    n_cmp++; if (valve_on !== 1'b0) begin n_bad++; $display("FAIL rst_valve: got %b want 0", valve_on); end
    n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL rst_done: got %b want 0000", done); end
    n_cmp++; if (aborted !== 1'b0) begin n_bad++; $display("FAIL rst_aborted: got %b want 0", aborted); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (ms_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b want 0", ms_tick); end
    @(negedge clk_100m);
    rst = 1'b0;
    repeat (8) step();
    n_cmp++; if (ms_tick !== 1'b0) begin n_bad++; $display("FAIL tick_c8: got %b want 0", ms_tick); end
    step();
    n_cmp++; if (ms_tick !== 1'b1) begin n_bad++; $display("FAIL tick_c9: got %b want 1", ms_tick); end
    step();
    n_cmp++; if (ms_tick !== 1'b0) begin n_bad++; $display("FAIL tick_c10: got %b want 0", ms_tick); end
  endtask

  task automatic test_single();
    int c;
    set_dur(0, 3);
    req = 4'b0001;
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL t1_grant: got %b want 0001", grant); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy: got %b want 1", busy); end
    n_cmp++; if (valve_on !== 1'b0) begin n_bad++; $display("FAIL t1_align_valve: got %b want 0", valve_on); end
    wait_rise(c);
    n_cmp++; if ((n % CLK_DIV) !== 0) begin n_bad++; $display("FAIL t1_rise_phase: got %0d want 0", n % CLK_DIV); end
    measure_high(c);
    n_cmp++; if (c !== 30) begin n_bad++; $display("FAIL t1_high: got %0d want 30", c); end
    n_cmp++; if (done !== 4'b0001) begin n_bad++; $display("FAIL t1_done: got %b want 0001", done); end
    n_cmp++; if (aborted !== 1'b0) begin n_bad++; $display("FAIL t1_aborted: got %b want 0", aborted); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL t1_grant_drop: got %b want 0000", grant); end
    req = 4'b0000;
    step();
    n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL t1_done_1cyc: got %b want 0000", done); end
    wait_idle(c);
    n_cmp++; if (c + 1 !== 20) begin n_bad++; $display("FAIL t1_gap: got %0d want 20", c + 1); end
  endtask

  task automatic test_round_robin();
    int c;
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < NCH; k++) set_dur(k, 1);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      c = 0;
      while (grant === 4'b0000 && c < BOUND) begin
        step();
        c++;
      end
      n_cmp++;
      if (c !== ((i == 0) ? 1 : 21)) begin
        n_bad++;
        $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, c, (i == 0) ? 1 : 21);
      end
      n_cmp++;
      if (grant !== exp_g[i]) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_g[i]);
      end
      wait_rise(c);
      measure_high(c);
      n_cmp++;
      if (c !== 10) begin n_bad++; $display("FAIL rr_high[%0d]: got %0d want 10", i, c); end
      n_cmp++;
      if (done !== exp_g[i]) begin
        n_bad++;
        $display("FAIL rr_done[%0d]: got %b want %b", i, done, exp_g[i]);
      end
      if (i == 4) req = 4'b0000;
    end
    wait_idle(c);
  endtask

  task automatic test_zero_dur();
    set_dur(2, 0);
    req = 4'b0100;
    step();
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL z_grant: got %b want 0100", grant); end
    n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL z_done_early: got %b want 0000", done); end
    step();
    n_cmp++; if (done !== 4'b0100) begin n_bad++; $display("FAIL z_done: got %b want 0100", done); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL z_grant_drop: got %b want 0000", grant); end
    n_cmp++; if (valve_on !== 1'b0) begin n_bad++; $display("FAIL z_valve: got %b want 0", valve_on); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL z_nogap: got %b want 0", busy); end
    req = 4'b0000;
    step();
    n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL z_done_1cyc: got %b want 0000", done); end
  endtask

  task automatic test_abort();
    int c;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 4'b0000 || aborted !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_idle: got busy=%b done=%b ab=%b want 0 0000 0", busy, done, aborted);
    end
    set_dur(1, 5);
    req = 4'b0010;
    wait_rise(c);
    repeat (20) step();
    n_cmp++; if (valve_on !== 1'b1) begin n_bad++; $display("FAIL ab_pre: got %b want 1", valve_on); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++; if (valve_on !== 1'b0) begin n_bad++; $display("FAIL ab_valve: got %b want 0", valve_on); end
    n_cmp++; if (done !== 4'b0010) begin n_bad++; $display("FAIL ab_done: got %b want 0010", done); end
    n_cmp++; if (aborted !== 1'b1) begin n_bad++; $display("FAIL ab_flag: got %b want 1", aborted); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL ab_grant: got %b want 0000", grant); end
    req = 4'b0000;
    step();
    n_cmp++; if (aborted !== 1'b0 || done !== 4'b0000) begin
      n_bad++;
      $display("FAIL ab_1cyc: got ab=%b done=%b want 0 0000", aborted, done);
    end
    wait_idle(c);
    n_cmp++; if (c + 1 !== 19) begin n_bad++; $display("FAIL ab_gap: got %0d want 19", c + 1); end
  endtask

  task automatic test_reset_mid();
    int c;
    set_dur(0, 4);
    req = 4'b0001;
    wait_rise(c);
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (valve_on !== 1'b0) begin n_bad++; $display("FAIL rm_valve: got %b want 0", valve_on); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rm_grant: got %b want 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL rm_done: got %b want 0000", done); end
    for (int k = 0; k < NCH; k++) set_dur(k, 1);
    req = 4'b1111;
    @(negedge clk_100m);
    rst = 1'b0;
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rm_prio: got %b want 0001", grant); end
    repeat (7) step();
    n_cmp++; if (ms_tick !== 1'b0) begin n_bad++; $display("FAIL rm_tick8: got %b want 0", ms_tick); end
    step();
    n_cmp++; if (ms_tick !== 1'b1) begin n_bad++; $display("FAIL rm_tick9: got %b want 1", ms_tick); end
    req = 4'b0000;
    wait_idle(c);
    n_cmp++; if (c !== 31) begin n_bad++; $display("FAIL rm_finish: got %0d want 31", c); end
  endtask

  task automatic test_latched_dur();
    int c;
    set_dur(0, 2);
    req = 4'b0001;
    wait_rise(c);
    repeat (3) step();
    req = 4'b0000;
    set_dur(0, 7);
    measure_high(c);
    n_cmp++; if (c + 3 !== 20) begin n_bad++; $display("FAIL lat_high: got %0d want 20", c + 3); end
    n_cmp++; if (done !== 4'b0001) begin n_bad++; $display("FAIL lat_done: got %b want 0001", done); end
    wait_idle(c);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lat_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dur();
    test_abort();
    test_reset_mid();
    test_latched_dur();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/valve_pulse_sched.md
Name: valve_pulse_sched

Overview:
- Shares one timed valve-drive output among NCH requesters (pump/valve control channels).
- Arbitrates pending pulse requests round-robin, then times the granted pulse in whole milliseconds.
- The millisecond timebase is an internal prescaler on the 100 MHz system clock.
- Sits between the processor's channel controllers and the single valve driver pin.

Parameters:
- NCH, 4, number of requesting channels (2..8)
- CLK_DIV, 100000, system clocks per millisecond tick; sims use 10
- DUR_W, 16, width of each requested duration in ms
- GAP_MS, 2, mandatory idle ticks between consecutive pulses (0 allowed)

Ports:
- clk_100m  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- req  input  NCH  per-channel pulse request level, held until done
- dur_ms  input  NCH*DUR_W  per-channel duration; channel i occupies bits [i*DUR_W +: DUR_W]
- abort  input  1  single-cycle strobe; terminates the current pulse
- grant  output  NCH  one-hot owner of the valve driver
- valve_on  output  1  valve drive
- done  output  NCH  1-cycle completion strobe to the owner
- aborted  output  1  1-cycle strobe, coincident with done, when the pulse was aborted
- busy  output  1  state != IDLE
- ms_tick  output  1  1-cycle tick strobe, exported

Behaviour:

Reset:
- Clock is clk_100m. Reset rst is asynchronous and active-high.
- On rst, all outputs go 0 immediately; prescaler=0; state=IDLE; last_grant=NCH-1.
- Reset mid-pulse drops valve_on at once. No done is issued.

Prescaler:
- presc counts 0..CLK_DIV-1 and wraps; it is free-running and independent of state.
- ms_tick=1 exactly while presc==CLK_DIV-1, so the first tick is cycle CLK_DIV-1 after reset release.

States: IDLE, ALIGN, ACTIVE, GAP.

IDLE:
- If req!=0, select the first set bit searching from (last_grant+1) mod NCH upward with wrap.
- Next cycle: grant=onehot(sel), last_grant=sel, rem=dur_ms[sel] (latched; later dur_ms changes are ignored).
- If the latched dur is 0: done[sel] pulses the following cycle with valve_on never asserted. grant drops with done and the block returns to IDLE with no gap. Otherwise go to ALIGN.

ALIGN:
- grant held, valve_on=0.
- On ms_tick, go to ACTIVE with valve_on=1 from the next cycle, so pulses are tick-aligned.

ACTIVE:
- valve_on=1. rem decrements on each ms_tick.
- On the ms_tick where rem==1: next cycle valve_on=0, grant=0, done[owner]=1 for 1 cycle, go to GAP.
- valve_on high time is exactly dur*CLK_DIV cycles.

GAP:
- grant=0, valve_on=0.
- GAP_MS=0: go to IDLE the next cycle.
- Otherwise count GAP_MS ms_ticks, then go to IDLE the cycle after the last one.
- A request pending during GAP is arbitrated in IDLE.

abort:
- Honoured only in ALIGN/ACTIVE.
- Next cycle: valve_on=0, grant=0, done[owner]=1, aborted=1, go to GAP.
- abort in IDLE/GAP is ignored.
- abort coincident with the final tick: treated as abort (aborted=1), single done.

Other rules:
- req deasserted by the owner mid-pulse is ignored; the pulse completes.
- Requester deasserts req after seeing done. A req still high after done re-enters arbitration and may be re-granted if it is the only one.
- grant, valve_on, done and aborted are registered outputs.
- rem is DUR_W bits; no overflow is possible.

Test Plan:
1. CLK_DIV=10, GAP_MS=2, req=0001, dur0=3 -> grant=0001 one cycle later; valve_on rises after the next tick and stays high 30 cycles; done[0] 1 cycle; busy clears 20 cycles later (ticks at 10-cycle spacing).
2. req=1111 held, all dur=1 -> grant order 0001,0010,0100,1000,0001; each valve_on 10 cycles; gaps ≥20 cycles between pulses.
3. dur2=0, req=0100 -> done[2] pulses 2 cycles after req; valve_on stays 0; block back in IDLE with no gap.
4. dur1=5, abort strobed 2 ticks into ACTIVE -> valve_on falls the next cycle; done[1]=aborted=1 for one cycle; GAP follows. abort in IDLE -> no effect.
5. rst asserted mid-ACTIVE (dur=4) -> valve_on/grant/busy 0 asynchronously; after release the first ms_tick is at cycle 9; ch0 has priority with last_grant reset.
6. Owner drops req and dur_ms changes mid-pulse -> pulse length unchanged (latched dur).
